// File: rtl/riscv_pkg.sv
// riscv_pkg: access-size encoding, data-memory FSM states and alignment helper.
package riscv_pkg;
  typedef enum logic [1:0] {
    Byte_Access     = 2'b00,
    Halfword_Access = 2'b01,
    Reserved        = 2'b10,
    Word_Access     = 2'b11
  } access_size_e;
  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_ACCESS
  } dmem_state_e;
  localparam int DMEM_WAIT_MAX = 15;
  localparam int DMEM_CNT_W = $clog2(DMEM_WAIT_MAX + 1);
  // Reserved sizes behave as words, so they share the word alignment rule.
  function automatic logic is_misaligned(access_size_e size, logic [1:0] lo);
    return size == Byte_Access ? 1'b0 : size == Halfword_Access ? lo[0] : lo != 2'b00;
  endfunction
endpackage

// File: rtl/riscv_dmem_lane_steer.sv
// riscv_dmem_lane_steer: byte-lane write mask/data steering and right-justified read extraction.
module riscv_dmem_lane_steer
  import riscv_pkg::*;
(
  input  access_size_e size,
  input  logic [1:0]   addr_lo,
  input  logic [31:0]  wr_data,
  input  logic [31:0]  ram_word,
  output logic [3:0]   lane_mask,
  output logic [31:0]  wr_word,
  output logic [31:0]  rd_data,
  output logic         misaligned
);
  logic        is_byte;
  logic        is_half;
  logic [1:0]  lane;
  logic [31:0] shifted;
  assign is_byte = size == Byte_Access;
  assign is_half = size == Halfword_Access;
  // Offending low bits are always dropped here; the top decides whether to flag instead.
  assign lane = is_byte ? addr_lo : is_half ? {addr_lo[1], 1'b0} : 2'b00;
  assign lane_mask = is_byte ? 4'b0001 << lane : is_half ? 4'b0011 << lane : 4'b1111;
  assign wr_word = is_byte ? {4{wr_data[7:0]}} : is_half ? {2{wr_data[15:0]}} : wr_data;
  assign shifted = ram_word >> {lane, 3'b000};
  assign rd_data = is_byte ? {24'b0, shifted[7:0]} : is_half ? {16'b0, shifted[15:0]} : ram_word;
  assign misaligned = is_misaligned(size, addr_lo);
endmodule

// File: rtl/riscv_data_mem.sv
// riscv_data_mem: single-outstanding data-memory responder with wait states.
// Define RISCV_DMEM_MISALIGN_ERR_EN to flag misaligned accesses instead of aligning them.
module riscv_data_mem
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_mem_req_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [1:0]  data_mem_byte_en_i,
  input  logic        data_mem_wr_i,
  input  logic [31:0] data_mem_wr_data_i,
  output logic [31:0] mem_rd_data_o,
  output logic        mem_ack_o,
  output logic        mem_busy_o,
  output logic        mem_err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0]         ram [DEPTH_WORDS];
  dmem_state_e         state;
  logic [DMEM_CNT_W-1:0] cnt;
  logic [AW+1:0]       addr_q;
  access_size_e        size_q;
  logic                wr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          lane_mask;
  logic [31:0]         wr_word;
  logic [31:0]         rd_steer;
  logic                misaligned;
  logic                mis_err;
  logic                ram_we;
  logic                unused_addr;
  assign unused_addr = ^data_mem_addr_i[31:AW+2];
`ifdef RISCV_DMEM_MISALIGN_ERR_EN
  assign mis_err = misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign mis_err = 1'b0;
`endif
  riscv_dmem_lane_steer u_steer (
    .size       (size_q),
    .addr_lo    (addr_q[1:0]),
    .wr_data    (wdata_q),
    .ram_word   (ram[addr_q[AW+1:2]]),
    .lane_mask  (lane_mask),
    .wr_word    (wr_word),
    .rd_data    (rd_steer),
    .misaligned (misaligned)
  );
  assign ram_we = state == DMEM_ACCESS && wr_q && !mis_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= DMEM_IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      size_q        <= Byte_Access;
      wr_q          <= 1'b0;
      wdata_q       <= '0;
      mem_rd_data_o <= '0;
      mem_ack_o     <= 1'b0;
      mem_busy_o    <= 1'b0;
      mem_err_o     <= 1'b0;
    end else begin
      mem_ack_o <= 1'b0;
      mem_err_o <= 1'b0;
      case (state)
        DMEM_IDLE: if (data_mem_req_i) begin
          addr_q     <= data_mem_addr_i[AW+1:0];
          size_q     <= access_size_e'(data_mem_byte_en_i);
          wr_q       <= data_mem_wr_i;
          wdata_q    <= data_mem_wr_data_i;
          cnt        <= '0;
          mem_busy_o <= 1'b1;
          state      <= WAIT_STATES > 0 ? DMEM_WAIT : DMEM_ACCESS;
        end
        DMEM_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == DMEM_CNT_W'(WAIT_STATES - 1)) state <= DMEM_ACCESS;
        end
        DMEM_ACCESS: begin
          mem_ack_o  <= 1'b1;
          mem_busy_o <= 1'b0;
          mem_err_o  <= mis_err;
          if (!wr_q && !mis_err) mem_rd_data_o <= rd_steer;
          state <= DMEM_IDLE;
        end
        default: state <= DMEM_IDLE;
      endcase
    end
  end
  // RAM has no reset; the write is gated by ACCESS, which reset clears asynchronously.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) ram[addr_q[AW+1:2]][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_riscv_data_mem.sv
// tb_riscv_data_mem: directed + random checks of two instances (0 and 3 wait states) against a byte-array model.
module tb_riscv_data_mem;
  import riscv_pkg::*;
`ifdef RISCV_DMEM_MISALIGN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0;
  logic        req3 = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  be = '0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rd_w [2];
  logic        ack_w [2];
  logic        busy_w [2];
  logic        err_w [2];
  logic [7:0]  mb [2][4096];
  logic [31:0] last_rd [2];
  int          checks = 0;
  int          passed = 0;
  int          fails = 0;
  always #5 clk = ~clk;
  riscv_data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .data_mem_req_i(req0), .data_mem_addr_i(addr),
    .data_mem_byte_en_i(be), .data_mem_wr_i(wr), .data_mem_wr_data_i(wdata),
    .mem_rd_data_o(rd_w[0]), .mem_ack_o(ack_w[0]), .mem_busy_o(busy_w[0]), .mem_err_o(err_w[0]));
  riscv_data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u3 (
    .clk(clk), .reset(reset), .data_mem_req_i(req3), .data_mem_addr_i(addr),
    .data_mem_byte_en_i(be), .data_mem_wr_i(wr), .data_mem_wr_data_i(wdata),
    .mem_rd_data_o(rd_w[1]), .mem_ack_o(ack_w[1]), .mem_busy_o(busy_w[1]), .mem_err_o(err_w[1]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_rd"}, rd_w[d], 32'h0);
      chk({tag, "_ack"}, {31'b0, ack_w[d]}, 32'h0);
      chk({tag, "_busy"}, {31'b0, busy_w[d]}, 32'h0);
      chk({tag, "_err"}, {31'b0, err_w[d]}, 32'h0);
    end
  endtask
  // d selects the instance (0: no wait states, 1: three); called #1 after a rising edge.
  task automatic do_op(input int d, input logic [1:0] size, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input bit poke);
    int ws, n;
    bit mis, skip;
    logic [31:0] ea, r;
    ws = d ? 3 : 0;
    n = size == 2'b00 ? 1 : size == 2'b01 ? 2 : 4;
    mis = (size == 2'b01 && a[0]) || (size[1] && a[1:0] != 2'b00);
    ea = (a % 4096) & ~(n - 1);
    skip = ERR_EN && mis;
    if (!skip && w) for (int k = 0; k < n; k++) mb[d][(ea + k) % 4096] = wd[8*k +: 8];
    if (!skip && !w) begin
      r = '0;
      for (int k = 0; k < n; k++) r[8*k +: 8] = mb[d][(ea + k) % 4096];
      last_rd[d] = r;
    end
    addr = a; be = size; wr = w; wdata = wd;
    if (d != 0) req3 = 1'b1; else req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0; req3 = 1'b0;
    chk("cap_busy", {31'b0, busy_w[d]}, 32'h1);
    chk("cap_ack", {31'b0, ack_w[d]}, 32'h0);
    for (int i = 0; i < ws; i++) begin
      if (poke && i == 0) begin req3 = 1'b1; addr = a ^ 32'h4; wr = 1'b1; wdata = ~wd; end
      @(posedge clk); #1;
      req3 = 1'b0;
      chk("wait_busy", {31'b0, busy_w[d]}, 32'h1);
      chk("wait_ack", {31'b0, ack_w[d]}, 32'h0);
    end
    @(posedge clk); #1;
    chk("ack", {31'b0, ack_w[d]}, 32'h1);
    chk("ack_busy", {31'b0, busy_w[d]}, 32'h0);
    chk("ack_err", {31'b0, err_w[d]}, {31'b0, skip});
    chk("rd_data", rd_w[d], last_rd[d]);
    @(posedge clk); #1;
    chk("ack_pulse", {31'b0, ack_w[d]}, 32'h0);
  endtask
  initial begin
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    do_op(0, 2'b11, 32'h10, 1'b1, 32'hDEADBEEF, 1'b0);
    do_op(0, 2'b11, 32'h10, 1'b0, 32'h0, 1'b0);
    chk("word_rd", rd_w[0], 32'hDEADBEEF);
    do_op(0, 2'b11, 32'h10, 1'b1, 32'h11223344, 1'b0);
    do_op(0, 2'b00, 32'h11, 1'b1, 32'h000000AA, 1'b0);
    do_op(0, 2'b00, 32'h11, 1'b0, 32'h0, 1'b0);
    chk("byte_rd", rd_w[0], 32'h000000AA);
    do_op(0, 2'b11, 32'h10, 1'b0, 32'h0, 1'b0);
    chk("byte_merge", rd_w[0], 32'h1122AA44);
    do_op(0, 2'b11, 32'h10, 1'b1, 32'h11223344, 1'b0);
    do_op(0, 2'b01, 32'h12, 1'b1, 32'h0000BEEF, 1'b0);
    do_op(0, 2'b01, 32'h12, 1'b0, 32'h0, 1'b0);
    chk("half_rd", rd_w[0], 32'h0000BEEF);
    do_op(0, 2'b10, 32'h10, 1'b0, 32'h0, 1'b0);
    chk("reserved_rd", rd_w[0], 32'hBEEF3344);
    do_op(0, 2'b11, 32'h13, 1'b1, 32'h55667788, 1'b0);
    do_op(0, 2'b11, 32'h10, 1'b0, 32'h0, 1'b0);
    chk("misalign_word", rd_w[0], ERR_EN ? 32'hBEEF3344 : 32'h55667788);
    do_op(1, 2'b11, 32'h20, 1'b1, 32'h0BADF00D, 1'b1);
    for (int i = 0; i < 6; i++) chk("no_extra_ack", {31'b0, ack_w[1] | busy_w[1]}, 32'h0);
    do_op(1, 2'b11, 32'h24, 1'b0, 32'h0, 1'b0);
    // Reset while a write sits in WAIT: nothing may land and no ack may appear.
    addr = 32'h20; be = 2'b11; wr = 1'b1; wdata = 32'hFFFFFFFF; req3 = 1'b1;
    @(posedge clk); #1;
    req3 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_idle_outputs("rst_mid");
    @(posedge clk); #1;
    chk_idle_outputs("rst_hold");
    reset = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_no_ack", {31'b0, ack_w[1]}, 32'h0);
    end
    do_op(1, 2'b11, 32'h20, 1'b0, 32'h0, 1'b0);
    chk("rst_old_data", rd_w[1], 32'h0BADF00D);
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++) do_op(d, 2'b11, 32'(w * 4), 1'b1, $urandom, 1'b0);
    for (int i = 0; i < 300; i++)
      do_op(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
            $urandom, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
